// File: rtl/machine_control.sv
// Trap and privilege sequencer: turns pipeline exceptions, interrupts, MRET and WFI into
// CSR strobes, PC mux selects, flush and halt. Outputs are combinational from state and inputs.
module machine_control (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ILLEGAL_INSTR,
  input  logic       MISALIGNED_INSTR,
  input  logic       MISALIGNED_LOAD,
  input  logic       MISALIGNED_STORE,
  input  logic       ECALL,
  input  logic       EBREAK,
  input  logic       MRET,
  input  logic       WFI,
  input  logic       MIE,
  input  logic       MEIE,
  input  logic       MTIE,
  input  logic       MSIE,
  input  logic       MEIP,
  input  logic       MTIP,
  input  logic       MSIP,
  output logic       I_OR_E,
  output logic [3:0] CAUSE_OUT,
  output logic       SET_CAUSE,
  output logic       SET_EPC,
  output logic       MIE_CLEAR,
  output logic       MIE_SET,
  output logic       INSTRET_INC,
  output logic [1:0] PC_SRC,
  output logic       FLUSH,
  output logic       HALT
);

  typedef enum logic [2:0] {
    S_RESET,
    S_OPERATING,
    S_TRAP_TAKEN,
    S_TRAP_RETURN,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_exc;
  logic        w_irq_pend;
  logic        w_irq;
  logic [3:0]  w_exc_cause;
  logic [3:0]  w_irq_cause;

  assign w_exc      = ILLEGAL_INSTR | MISALIGNED_INSTR | MISALIGNED_LOAD |
                      MISALIGNED_STORE | ECALL | EBREAK;
  assign w_irq_pend = (MEIE & MEIP) | (MTIE & MTIP) | (MSIE & MSIP);
  assign w_irq      = MIE & w_irq_pend;

  assign w_exc_cause = MISALIGNED_INSTR ? 4'd0  :
                       ILLEGAL_INSTR    ? 4'd2  :
                       ECALL            ? 4'd11 :
                       EBREAK           ? 4'd3  :
                       MISALIGNED_LOAD  ? 4'd4  : 4'd6;

  // Software outranks timer, matching the Steel Core cause ordering.
  assign w_irq_cause = (MEIE & MEIP) ? 4'd11 :
                       (MSIE & MSIP) ? 4'd3  : 4'd7;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:       w_next = S_OPERATING;
      S_OPERATING: begin
        if (w_exc || w_irq) w_next = S_TRAP_TAKEN;
        else if (MRET)      w_next = S_TRAP_RETURN;
        else if (WFI)       w_next = S_WAIT;
        else                w_next = S_OPERATING;
      end
      S_TRAP_TAKEN:  w_next = S_OPERATING;
      S_TRAP_RETURN: w_next = S_OPERATING;
      S_WAIT: begin
        if (w_irq_pend) w_next = MIE ? S_TRAP_TAKEN : S_OPERATING;
        else            w_next = S_WAIT;
      end
      default:       w_next = S_RESET;
    endcase
  end

  always_comb begin
    I_OR_E      = 1'b0;
    CAUSE_OUT   = 4'd0;
    SET_CAUSE   = 1'b0;
    SET_EPC     = 1'b0;
    MIE_CLEAR   = 1'b0;
    MIE_SET     = 1'b0;
    INSTRET_INC = 1'b0;
    PC_SRC      = 2'b11;
    FLUSH       = 1'b0;
    HALT        = 1'b0;
    case (r_state)
      S_RESET: begin
        PC_SRC = 2'b00;
        FLUSH  = 1'b1;
      end
      S_OPERATING: begin
        if (w_exc || w_irq) begin
          SET_CAUSE = 1'b1;
          SET_EPC   = 1'b1;
          MIE_CLEAR = 1'b1;
          FLUSH     = 1'b1;
          I_OR_E    = ~w_exc;
          CAUSE_OUT = w_exc ? w_exc_cause : w_irq_cause;
        end else if (MRET) begin
          MIE_SET     = 1'b1;
          FLUSH       = 1'b1;
          INSTRET_INC = 1'b1;
        end else if (WFI) begin
          INSTRET_INC = 1'b1;
          HALT        = 1'b1;
          FLUSH       = 1'b1;
        end else begin
          INSTRET_INC = 1'b1;
        end
      end
      S_TRAP_TAKEN: begin
        PC_SRC = 2'b10;
        FLUSH  = 1'b1;
      end
      S_TRAP_RETURN: begin
        PC_SRC = 2'b01;
        FLUSH  = 1'b1;
      end
      S_WAIT: begin
        HALT  = 1'b1;
        FLUSH = 1'b1;
        // PC stays held while the wake-up trap saves it as EPC.
        if (w_irq_pend) begin
          if (MIE) begin
            SET_CAUSE = 1'b1;
            SET_EPC   = 1'b1;
            MIE_CLEAR = 1'b1;
            I_OR_E    = 1'b1;
            CAUSE_OUT = w_irq_cause;
          end else begin
            HALT = 1'b0;
          end
        end
      end
      default: begin
        PC_SRC = 2'b00;
        FLUSH  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_control.sv
// Randomized and directed bench for machine_control against a cycle-level behavioural model.
module tb_machine_control;

  logic CLK = 1'b0;
  logic RESET;
  logic ILLEGAL_INSTR, MISALIGNED_INSTR, MISALIGNED_LOAD, MISALIGNED_STORE, ECALL, EBREAK;
  logic MRET, WFI;
  logic MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP;
  logic       I_OR_E;
  logic [3:0] CAUSE_OUT;
  logic       SET_CAUSE, SET_EPC, MIE_CLEAR, MIE_SET, INSTRET_INC;
  logic [1:0] PC_SRC;
  logic       FLUSH, HALT;

  machine_control dut (
    .CLK(CLK), .RESET(RESET),
    .ILLEGAL_INSTR(ILLEGAL_INSTR), .MISALIGNED_INSTR(MISALIGNED_INSTR),
    .MISALIGNED_LOAD(MISALIGNED_LOAD), .MISALIGNED_STORE(MISALIGNED_STORE),
    .ECALL(ECALL), .EBREAK(EBREAK), .MRET(MRET), .WFI(WFI),
    .MIE(MIE), .MEIE(MEIE), .MTIE(MTIE), .MSIE(MSIE),
    .MEIP(MEIP), .MTIP(MTIP), .MSIP(MSIP),
    .I_OR_E(I_OR_E), .CAUSE_OUT(CAUSE_OUT), .SET_CAUSE(SET_CAUSE), .SET_EPC(SET_EPC),
    .MIE_CLEAR(MIE_CLEAR), .MIE_SET(MIE_SET), .INSTRET_INC(INSTRET_INC),
    .PC_SRC(PC_SRC), .FLUSH(FLUSH), .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  // {I_OR_E, CAUSE_OUT, SET_CAUSE, SET_EPC, MIE_CLEAR, MIE_SET, INSTRET_INC, PC_SRC, FLUSH, HALT}
  logic [13:0] got_vec;
  assign got_vec = {I_OR_E, CAUSE_OUT, SET_CAUSE, SET_EPC, MIE_CLEAR, MIE_SET,
                    INSTRET_INC, PC_SRC, FLUSH, HALT};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got ioe=%b cause=%0d sc/se/mc/ms/ii=%b pc=%b fl=%b h=%b, want ioe=%b cause=%0d sc/se/mc/ms/ii=%b pc=%b fl=%b h=%b",
                  tag, got[13], got[12:9], got[8:4], got[3:2], got[1], got[0],
                  exp[13], exp[12:9], exp[8:4], exp[3:2], exp[1], exp[0]);
  endtask

  // Model: a pending redirect (PC source for the coming cycle, -1 = none) and a sleeping flag.
  int m_redir = 0;
  bit m_wait  = 0;

  function automatic logic [13:0] pack(bit ioe, int cause, bit sc, bit ms, bit ii,
                                       int pc, bit fl, bit h);
    logic [3:0] c;
    logic [1:0] p;
    c = cause[3:0];
    p = pc[1:0];
    return {ioe, c, sc, sc, sc, ms, ii, p, fl, h};
  endfunction

  task automatic step(input string tag);
    bit e[6];
    int ec[6] = '{0, 2, 11, 3, 4, 6};
    bit s[3];
    int ic[3] = '{11, 3, 7};
    int exc_cause, irq_cause;
    bit pend;
    logic [13:0] exp;
    #1;
    e = '{MISALIGNED_INSTR, ILLEGAL_INSTR, ECALL, EBREAK, MISALIGNED_LOAD, MISALIGNED_STORE};
    s = '{MEIE & MEIP, MSIE & MSIP, MTIE & MTIP};
    exc_cause = -1;
    for (int i = 5; i >= 0; i--) if (e[i]) exc_cause = ec[i];
    irq_cause = -1;
    for (int i = 2; i >= 0; i--) if (s[i]) irq_cause = ic[i];
    pend = (irq_cause >= 0);
    if (RESET) begin
      exp = pack(0, 0, 0, 0, 0, 0, 1, 0);
      m_redir = 0;
      m_wait  = 0;
    end else if (m_redir >= 0) begin
      exp = pack(0, 0, 0, 0, 0, m_redir, 1, 0);
      m_redir = -1;
    end else if (m_wait) begin
      if (pend && MIE) begin
        exp = pack(1, irq_cause, 1, 0, 0, 3, 1, 1);
        m_redir = 2;
        m_wait  = 0;
      end else if (pend) begin
        exp = pack(0, 0, 0, 0, 0, 3, 1, 0);
        m_wait = 0;
      end else begin
        exp = pack(0, 0, 0, 0, 0, 3, 1, 1);
      end
    end else if (exc_cause >= 0) begin
      exp = pack(0, exc_cause, 1, 0, 0, 3, 1, 0);
      m_redir = 2;
    end else if (MIE && pend) begin
      exp = pack(1, irq_cause, 1, 0, 0, 3, 1, 0);
      m_redir = 2;
    end else if (MRET) begin
      exp = pack(0, 0, 0, 1, 1, 3, 1, 0);
      m_redir = 1;
    end else if (WFI) begin
      exp = pack(0, 0, 0, 0, 1, 3, 1, 1);
      m_wait = 1;
    end else begin
      exp = pack(0, 0, 0, 0, 1, 3, 0, 0);
    end
    check(tag, got_vec, exp);
    @(negedge CLK);
  endtask

  // exc = {ILLEGAL, MIS_INSTR, MIS_LOAD, MIS_STORE, ECALL, EBREAK}; csr = {MIE,MEIE,MTIE,MSIE,MEIP,MTIP,MSIP}
  task automatic set_in(input logic [5:0] exc, input logic mret, input logic wfi,
                        input logic [6:0] csr);
    {ILLEGAL_INSTR, MISALIGNED_INSTR, MISALIGNED_LOAD, MISALIGNED_STORE, ECALL, EBREAK} = exc;
    MRET = mret;
    WFI  = wfi;
    {MIE, MEIE, MTIE, MSIE, MEIP, MTIP, MSIP} = csr;
  endtask

  initial begin
    RESET = 1'b1;
    set_in('0, 0, 0, '0);
    @(negedge CLK);
    step("rst_hold0");
    step("rst_hold1");
    RESET = 1'b0;
    step("boot");
    step("run");

    set_in(6'b100010, 0, 0, '0); step("ill_ecall");
    set_in('0, 0, 0, '0);        step("ill_trap_pc");
    step("ill_resume");

    set_in('0, 0, 0, 7'b1110110); step("irq_ext");
    set_in('0, 0, 0, '0);         step("irq_ext_pc");
    set_in('0, 0, 0, 7'b1110010); step("irq_tmr");
    set_in('0, 0, 0, '0);         step("irq_tmr_pc");
    set_in('0, 0, 0, 7'b0110110); step("irq_masked");

    set_in('0, 1, 0, '0);        step("mret");
    set_in('0, 0, 0, '0);        step("mret_pc");
    set_in(6'b001000, 1, 0, '0); step("mret_ld");
    set_in('0, 0, 0, '0);        step("mret_ld_pc");

    set_in('0, 0, 1, '0);         step("wfi");
    set_in('0, 0, 0, '0);
    repeat (5) step("wfi_idle");
    set_in(6'b100000, 0, 0, '0);  step("wfi_exc_ignored");
    set_in('0, 0, 0, 7'b1001001); step("wfi_wake_irq");
    set_in('0, 0, 0, '0);         step("wfi_wake_pc");

    set_in('0, 0, 1, '0);         step("wfi2");
    set_in('0, 0, 0, '0);         step("wfi2_idle");
    set_in('0, 0, 0, 7'b0001001); step("wfi_wake_masked");
    set_in('0, 0, 0, '0);         step("wfi_post_wake");

    set_in(6'b010000, 0, 0, '0);  step("mis_instr");
    set_in('0, 0, 0, '0);
    #1 check("trap_taken_pre", got_vec, pack(0, 0, 0, 0, 0, 2, 1, 0));
    RESET = 1'b1;
    #1 check("async_rst", got_vec, pack(0, 0, 0, 0, 0, 0, 1, 0));
    m_redir = 0;
    m_wait  = 0;
    @(negedge CLK);
    step("rst_mid_hold");
    RESET = 1'b0;
    step("rst_mid_boot");
    step("rst_mid_run");

    for (int n = 0; n < 3000; n++) begin
      if (RESET) RESET = ($urandom_range(0, 1) == 0);
      else       RESET = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 6; k++) begin
        case (k)
          0: ILLEGAL_INSTR    = ($urandom_range(0, 15) == 0);
          1: MISALIGNED_INSTR = ($urandom_range(0, 15) == 0);
          2: MISALIGNED_LOAD  = ($urandom_range(0, 15) == 0);
          3: MISALIGNED_STORE = ($urandom_range(0, 15) == 0);
          4: ECALL            = ($urandom_range(0, 15) == 0);
          default: EBREAK     = ($urandom_range(0, 15) == 0);
        endcase
      end
      MRET = ($urandom_range(0, 9) == 0);
      WFI  = ($urandom_range(0, 7) == 0);
      MIE  = $urandom_range(0, 1);
      MEIE = $urandom_range(0, 1);
      MTIE = $urandom_range(0, 1);
      MSIE = $urandom_range(0, 1);
      MEIP = ($urandom_range(0, 5) == 0);
      MTIP = ($urandom_range(0, 5) == 0);
      MSIP = ($urandom_range(0, 5) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
